// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width, master state codes, select level.
// Imported by both the SPI master and the existing SPI slave.
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic SS_ACTIVE = 1'b1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOW  = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOW  = ST_LOW,
    S_HIGH = ST_HIGH,
    S_HOLD = ST_HOLD,
    S_GAP  = ST_GAP
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master.
// The restart input zeroes the count so each state gets a full period.
module spi_clk_div #(
  parameter int HALF_DIV = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(HALF_DIV - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI initiator: one MSB-first full-duplex word per start request.
// sclk idles low; master drives on fall, samples miso on fall.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HALF_DIV = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              ss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW = $clog2(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [BW-1:0]     bit_cnt;
  logic              tick;
  logic              restart;

  // Every state change restarts the divider.
  assign restart = (state == S_IDLE) ? start : tick;

  spi_clk_div #(
    .HALF_DIV(HALF_DIV)
  ) u_div (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ss       <= ~SS_ACTIVE;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          tx_shift <= tx_data;
          rx_shift <= '0;
          bit_cnt  <= '0;
          ss       <= SS_ACTIVE;
          sclk     <= 1'b0;
          mosi     <= tx_data[DATA_W-1];
          busy     <= 1'b1;
          state    <= S_LOW;
        end
        S_LOW: if (tick) begin
          sclk  <= 1'b1;
          state <= S_HIGH;
        end
        S_HIGH: if (tick) begin
          sclk     <= 1'b0;
          rx_shift <= {rx_shift[DATA_W-2:0], miso};
          if (bit_cnt == BW'(DATA_W - 1)) begin
            state <= S_HOLD;
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            tx_shift <= tx_shift << 1;
            mosi     <= tx_shift[DATA_W-2];
            state    <= S_LOW;
          end
        end
        S_HOLD: if (tick) begin
          ss      <= ~SS_ACTIVE;
          mosi    <= 1'b0;
          rx_data <= rx_shift;
          done    <= 1'b1;
          state   <= S_GAP;
        end
        S_GAP: if (tick) begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator that pairs with the existing SPI slave. Drives ss, sclk and mosi, and samples miso.
- Transfers one DATA_W-bit word per start request, MSB first, full duplex.
- sclk idles low. ss is active-high, so ss=1 selects the slave for the whole word.
- Sits between the system-side controller (start/busy/done handshake) and the off-block SPI pins.

Parameters:
- DATA_W, 8, bits per transfer.
- HALF_DIV, 2, sys_clk cycles per sclk half-period. Legal range is HALF_DIV >= 1.

Ports:
- sys_clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  transfer request; sampled only in IDLE.
- tx_data  input  DATA_W  word to send; captured on the accepted start cycle.
- rx_data  output  DATA_W  last received word; updated when done pulses.
- busy  output  1  high from the cycle after start is accepted until the return to IDLE.
- done  output  1  one-cycle pulse when the word is complete.
- ss  output  1  slave select, active-high.
- sclk  output  1  serial clock, idle low.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in from the slave.

Behaviour:
- Reset (async, rst_n=0): the block returns to IDLE and all outputs take their reset values.
  - ss=0, sclk=0, mosi=0, busy=0, done=0, rx_data=0.
  - The shift registers, bit counter and divider counter clear.
  - Reset mid-transfer aborts the word; ss drops immediately and no done is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- Divider: a counter produces a tick every HALF_DIV cycles. It restarts at 0 on every state entry.
- States: IDLE, LOW, HIGH, HOLD, GAP.
- IDLE, start=1:
  - tx_data is loaded into tx_shift and bit_cnt is cleared.
  - Next cycle: ss=1, mosi=tx_data[DATA_W-1], sclk=0, busy=1.
  - State moves to LOW.
- LOW, on tick: sclk goes to 1 and state moves to HIGH. The slave samples mosi on this rising edge.
- HIGH, on tick: sclk goes to 0 and rx_shift takes {rx_shift[DATA_W-2:0], miso}. The slave updates miso on sclk rise, so the master samples on the fall.
  - If bit_cnt == DATA_W-1, state moves to HOLD.
  - Otherwise bit_cnt increments, mosi takes the next lower tx bit, and state moves to LOW.
- HOLD, on tick:
  - ss=0, mosi=0.
  - rx_data takes the final rx_shift value, including the last sampled bit.
  - done=1 for exactly one cycle.
  - State moves to GAP.
- GAP, on tick: state moves to IDLE and busy=0. This guarantees a minimum ss-low time of one half-period.
- Timing, with start accepted at cycle 0 and H = HALF_DIV:
  - sclk rising edges at cycles 1+H, 1+3H, … ; falling edges at 1+2H, … , 1+2·DATA_W·H.
  - done at cycle 1+(2·DATA_W+1)·H.
  - busy falls at cycle 1+(2·DATA_W+2)·H.
- start while busy=1 is ignored; it is not queued.
- start held high continuously begins the next word on the first IDLE cycle.
- tx_data changes after acceptance have no effect on the word in flight.
- HALF_DIV=1 is legal: sclk = sys_clk/2.
- Exactly DATA_W rising and DATA_W falling sclk edges occur per word. No sclk edge occurs while ss=0.

Decomposition:
- Shared package spi_pkg holds:
  - DATA_W default.
  - Master state encodings (IDLE, LOW, HIGH, HOLD, GAP) as localparams.
  - The ss active level constant (1'b1), shared with the slave.
- Sub-module spi_clk_div: HALF_DIV half-period tick counter with a synchronous restart input.

Test Plan:
- Reset then idle: rst_n=0 mid-run → ss=0, sclk=0, mosi=0, busy=0, done=0, rx_data=8'h00. Outputs stay there for 100 cycles with start=0.
- Loopback, HALF_DIV=2: miso tied to mosi, start with tx_data=8'hA5 →
  - mosi sequence 1,0,1,0,0,1,0,1 at the rising edges;
  - done at cycle 35, rx_data=8'hA5, busy low at cycle 37;
  - exactly 8 sclk rises.
- Slave model: a behavioural slave preloaded with 8'h3C shifts on sclk rise; master sends 8'h96 → master rx_data=8'h3C, slave captures 8'h96.
- Back-to-back, HALF_DIV=1: start held high with tx_data=8'hFF then 8'h00 → two words, ss low for at least one half-period between them, two done pulses each one cycle wide.
- Ignore while busy: pulse start with tx_data=8'h12 mid-transfer of 8'h81 → word 8'h81 completes unchanged and no extra transfer follows.
- Abort: rst_n low during bit 4 → ss falls asynchronously, no done pulse. The next start with 8'h5A completes correctly.
